// File: rtl/aes2_ct_capture.sv
// -----------------------------------------------------------------------------
// aes2_ct_capture
//
// Ciphertext capture stage of the AES-192 peripheral. Sits between the AES
// core's ciphertext output and the peripheral register read map. Each rising
// edge of the core's out_valid level pushes the 128-bit ciphertext into a
// small FIFO so software can drain back-to-back blocks at its own pace.
// Blocks arriving while the FIFO is full are dropped and counted.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, 2..16)
//   THRESH  occupancy at or above which irq_o asserts (1..DEPTH)
//
// Ports:
//   clk_i       sole clock
//   rst_i       synchronous, active-high reset
//   ct_i        ciphertext from the AES core
//   ct_valid_i  AES core out_valid level (held high while result is held)
//   start_i     AES start level as written by software
//   pop_i       one-cycle strobe: discard head entry
//   rd_sel_i    head word select (0=[31:0] .. 3=[127:96])
//   clr_i       one-cycle synchronous flush
//   rdata_o     selected 32-bit word of the head entry (0 when empty)
//   count_o     current occupancy
//   empty_o     occupancy is zero
//   full_o      occupancy equals DEPTH
//   ovf_cnt_o   saturating count of dropped blocks
//   irq_o       registered threshold interrupt
//   latency_o   start-to-valid cycle count
//
// Build option:
//   AES2_CT_LATENCY_EN  when defined, measures cycles from a rising edge of
//                       start_i to the next captured valid edge and reports
//                       it on latency_o. When undefined, latency_o is 0.
// -----------------------------------------------------------------------------
module aes2_ct_capture #(
    parameter int DEPTH  = 4,
    parameter int THRESH = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [127:0]             ct_i,
    input  logic                     ct_valid_i,
    input  logic                     start_i,
    input  logic                     pop_i,
    input  logic [1:0]               rd_sel_i,
    input  logic                     clr_i,
    output logic [31:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [7:0]               ovf_cnt_o,
    output logic                     irq_o,
    output logic [15:0]              latency_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [7:0]    ovf_cnt;
    logic          irq;
    logic          prev_v;

    logic          push_ev;
    logic          do_push;
    logic          do_pop;
    logic          ovf_ev;
    logic [127:0]  head;

    // NOTE: every signal driven here gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_ev   = 1'b0;
        do_pop    = 1'b0;
        do_push   = 1'b0;
        ovf_ev    = 1'b0;
        count_nxt = count;

        push_ev = ct_valid_i & ~prev_v;
        do_pop  = pop_i && (count != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = push_ev && ((count < DEPTH_C) || do_pop);
        ovf_ev  = push_ev && !do_push;
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf_cnt <= 8'h00;
            irq     <= 1'b0;
            // Start high so a valid level already asserted at reset release
            // is not mistaken for a new result.
            prev_v  <= 1'b1;
        end else if (clr_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf_cnt <= 8'h00;
            irq     <= 1'b0;
            prev_v  <= ct_valid_i;
        end else begin
            prev_v <= ct_valid_i;
            count  <= count_nxt;
            irq    <= (count_nxt >= THRESH_C);
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (ovf_ev && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

    // NOTE: the storage array carries no reset; only pointers and occupancy
    // define which entries are valid, so stale contents are never exposed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clr_i && do_push) begin
            mem[wptr] <= ct_i;
        end
    end

    assign head      = mem[rptr];
    assign rdata_o   = (count == '0) ? 32'h0 : head[{rd_sel_i, 5'd0} +: 32];
    assign count_o   = count;
    assign empty_o   = (count == '0);
    assign full_o    = (count == DEPTH_C);
    assign ovf_cnt_o = ovf_cnt;
    assign irq_o     = irq;

`ifdef AES2_CT_LATENCY_EN
    logic        prev_s;
    logic        lat_armed;
    logic [15:0] lat_cnt;
    logic [15:0] lat_cnt_nxt;
    logic [15:0] latency_q;

    // Counter value including the current cycle, so a valid edge N cycles
    // after the start edge reports N.
    always_comb begin
        lat_cnt_nxt = lat_cnt;
        if (lat_armed && (lat_cnt != 16'hFFFF)) begin
            lat_cnt_nxt = lat_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_s    <= 1'b1;
            lat_armed <= 1'b0;
            lat_cnt   <= 16'h0;
            latency_q <= 16'h0;
        end else if (clr_i) begin
            prev_s    <= start_i;
            lat_armed <= 1'b0;
            lat_cnt   <= 16'h0;
            latency_q <= 16'h0;
        end else begin
            prev_s  <= start_i;
            lat_cnt <= lat_cnt_nxt;
            if (push_ev && lat_armed) begin
                latency_q <= lat_cnt_nxt;
                lat_armed <= 1'b0;
            end
            // A new start edge re-arms after any capture in the same cycle.
            if (start_i && !prev_s) begin
                lat_cnt   <= 16'h0;
                lat_armed <= 1'b1;
            end
        end
    end

    assign latency_o = latency_q;
`else
    logic unused_start;
    assign unused_start = start_i;
    assign latency_o    = 16'h0;
`endif

endmodule

// File: tb/tb_aes2_ct_capture.sv
// -----------------------------------------------------------------------------
// tb_aes2_ct_capture
//
// Self-checking bench for aes2_ct_capture (DEPTH=4, THRESH=2). A queue-based
// reference model tracks FIFO contents, overflow count, interrupt and
// start-to-valid latency; every cycle the DUT outputs are compared with it.
// Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_aes2_ct_capture;

    localparam int DEPTH  = 4;
    localparam int THRESH = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [127:0] ct_i;
    logic         ct_valid_i;
    logic         start_i;
    logic         pop_i;
    logic [1:0]   rd_sel_i;
    logic         clr_i;
    logic [31:0]  rdata_o;
    logic [2:0]   count_o;
    logic         empty_o;
    logic         full_o;
    logic [7:0]   ovf_cnt_o;
    logic         irq_o;
    logic [15:0]  latency_o;

    always #5 clk_i = ~clk_i;

    aes2_ct_capture #(
        .DEPTH (DEPTH),
        .THRESH(THRESH)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ct_i      (ct_i),
        .ct_valid_i(ct_valid_i),
        .start_i   (start_i),
        .pop_i     (pop_i),
        .rd_sel_i  (rd_sel_i),
        .clr_i     (clr_i),
        .rdata_o   (rdata_o),
        .count_o   (count_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .ovf_cnt_o (ovf_cnt_o),
        .irq_o     (irq_o),
        .latency_o (latency_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [127:0] q[$];
    int           m_ovf;
    bit           m_irq;
    bit           m_prev_v;
    bit           m_prev_s;
    bit           m_armed;
    int           m_lat;
    int           cyc;
    int           start_cyc;

    // Apply current inputs for one clock, update the model, then compare.
    task automatic cycle();
        bit           edge_v;
        bit           pop_ok;
        logic [127:0] h;
        logic [31:0]  exp_rd;
        edge_v = ct_valid_i && !m_prev_v;
        if (rst_i) begin
            q.delete();
            m_ovf = 0; m_irq = 0; m_prev_v = 1; m_prev_s = 1;
            m_armed = 0; m_lat = 0;
        end else if (clr_i) begin
            q.delete();
            m_ovf = 0; m_irq = 0; m_prev_v = ct_valid_i; m_prev_s = start_i;
            m_armed = 0; m_lat = 0;
        end else begin
            pop_ok = pop_i && (q.size() > 0);
            if (edge_v) begin
                if (q.size() < DEPTH || pop_ok) q.push_back(ct_i);
                else if (m_ovf < 255) m_ovf++;
            end
            if (pop_ok) void'(q.pop_front());
            m_irq = (q.size() >= THRESH);
            if (edge_v && m_armed) begin
                m_lat   = (cyc - start_cyc > 65535) ? 65535 : cyc - start_cyc;
                m_armed = 0;
            end
            if (start_i && !m_prev_s) begin
                m_armed   = 1;
                start_cyc = cyc;
            end
            m_prev_v = ct_valid_i;
            m_prev_s = start_i;
        end
        cyc++;
        @(posedge clk_i);
        #1;
        if (q.size() == 0) exp_rd = 32'h0;
        else begin
            h      = q[0];
            exp_rd = h[rd_sel_i*32 +: 32];
        end
        check("count", count_o, q.size());
        check("empty", empty_o, q.size() == 0);
        check("full", full_o, q.size() == DEPTH);
        check("ovf", ovf_cnt_o, m_ovf);
        check("irq", irq_o, m_irq);
        check("rdata", rdata_o, exp_rd);
`ifdef AES2_CT_LATENCY_EN
        check("latency", latency_o, m_lat);
`else
        check("latency", latency_o, 0);
`endif
    endtask

    // One valid pulse: low for a cycle, then high with the given data.
    task automatic pulse(input logic [127:0] v);
        ct_valid_i = 1'b0;
        cycle();
        ct_valid_i = 1'b1;
        ct_i       = v;
        cycle();
    endtask

    task automatic do_clear();
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
    endtask

    logic [31:0]  words[4];
    logic [127:0] blk;

    initial begin
        rst_i = 1'b1; ct_valid_i = 1'b1; ct_i = '0; start_i = 1'b0;
        pop_i = 1'b0; rd_sel_i = 2'd0; clr_i = 1'b0;
        m_prev_v = 1; m_prev_s = 1; cyc = 0; start_cyc = 0;
        m_ovf = 0; m_irq = 0; m_armed = 0; m_lat = 0;

        // Reset with valid held high, release, hold: nothing captured.
        cycle(); cycle();
        rst_i = 1'b0;
        repeat (3) cycle();
        check("no_capture_count", count_o, 0);
        check("no_capture_empty", empty_o, 1);

        // First real edge; read all four words.
        words[0] = 32'hCCDDEEFF; words[1] = 32'h8899AABB;
        words[2] = 32'h44556677; words[3] = 32'h00112233;
        pulse(128'h00112233_44556677_8899AABB_CCDDEEFF);
        check("first_count", count_o, 1);
        for (int s = 0; s < 4; s++) begin
            rd_sel_i = 2'(s);
            cycle();
            check("word_sel", rdata_o, words[s]);
        end
        rd_sel_i = 2'd0;
        do_clear();

        // Six pulses, no pops: four kept, two dropped.
        for (int i = 1; i <= 6; i++) pulse({4{32'(i)}});
        check("ovf_full", full_o, 1);
        check("ovf_count", count_o, 4);
        check("ovf_cnt", ovf_cnt_o, 2);
        ct_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("pop_order", rdata_o, 32'(i));
            pop_i = 1'b1; cycle(); pop_i = 1'b0;
        end
        check("drained_empty", empty_o, 1);
        check("drained_rdata", rdata_o, 0);

        // Full FIFO: valid edge and pop together.
        for (int i = 11; i <= 14; i++) pulse({4{32'(i)}});
        ct_valid_i = 1'b0; cycle();
        ct_valid_i = 1'b1; ct_i = {4{32'd15}}; pop_i = 1'b1;
        cycle();
        pop_i = 1'b0;
        check("pushpop_count", count_o, 4);
        check("pushpop_ovf", ovf_cnt_o, 2);
        check("pushpop_head", rdata_o, 32'd12);
        do_clear();

        // Threshold interrupt with THRESH=2.
        pulse({4{32'hA1}});
        check("irq_one", irq_o, 0);
        pulse({4{32'hA2}});
        check("irq_two", irq_o, 1);
        ct_valid_i = 1'b0;
        pop_i = 1'b1; cycle(); pop_i = 1'b0;
        check("irq_after_pop", irq_o, 0);
        pop_i = 1'b1; cycle(); cycle(); pop_i = 1'b0;
        check("pop_empty_count", count_o, 0);

        // clr_i coincident with a valid edge on a 3-entry FIFO, ovf=5.
        for (int i = 0; i < 9; i++) pulse({4{32'(100 + i)}});
        ct_valid_i = 1'b0;
        pop_i = 1'b1; cycle(); pop_i = 1'b0;
        check("pre_clr_count", count_o, 3);
        check("pre_clr_ovf", ovf_cnt_o, 5);
        ct_valid_i = 1'b1; ct_i = {4{32'hDEAD}}; clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        check("clr_count", count_o, 0);
        check("clr_ovf", ovf_cnt_o, 0);
        check("clr_irq", irq_o, 0);

        // Start-to-valid latency of 13 cycles.
        ct_valid_i = 1'b0; start_i = 1'b0; cycle();
        start_i = 1'b1; cycle();
        repeat (12) cycle();
        ct_valid_i = 1'b1; ct_i = {4{32'h5A5A}};
        cycle();
`ifdef AES2_CT_LATENCY_EN
        check("latency_13", latency_o, 13);
`else
        check("latency_off", latency_o, 0);
`endif
        start_i = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            ct_valid_i = ($urandom_range(0, 2) != 0) ? ~ct_valid_i : ct_valid_i;
            blk        = {$urandom, $urandom, $urandom, $urandom};
            ct_i       = blk;
            pop_i      = ($urandom_range(0, 3) == 0);
            rd_sel_i   = 2'($urandom_range(0, 3));
            clr_i      = ($urandom_range(0, 60) == 0);
            start_i    = ($urandom_range(0, 15) == 0) ? ~start_i : start_i;
            cycle();
        end
        clr_i = 1'b0; pop_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes2_ct_capture.md
Name: aes2_ct_capture

Overview:
- Downstream stage of the AES-192 peripheral: sits between the AES core's ciphertext output (out/out_valid) and the peripheral register read map.
- Detects each new ciphertext on the rising edge of the core's valid flag.
- Queues results in a small FIFO so software can read back-to-back blocks without losing any.
- Provides status, overflow accounting and a threshold interrupt.

Parameters:
- DEPTH, 4, FIFO entries of 128 bits; power of two, 2..16.
- THRESH, 1, occupancy at or above which irq_o asserts; 1..DEPTH.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- ct_i  in  128  ciphertext from AES core.
- ct_valid_i  in  1  AES core out_valid (level; stays high while result held).
- start_i  in  1  AES start level as written by software.
- pop_i  in  1  one-cycle strobe: discard head entry.
- rd_sel_i  in  2  head word select: 0=[31:0], 1=[63:32], 2=[95:64], 3=[127:96].
- clr_i  in  1  one-cycle synchronous flush.
- rdata_o  out  32  selected word of head entry.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- empty_o  out  1  count_o==0.
- full_o  out  1  count_o==DEPTH.
- ovf_cnt_o  out  8  dropped-block counter, saturating.
- irq_o  out  1  registered threshold interrupt.
- latency_o  out  16  start-to-valid cycle count (optional feature).

Behaviour:
- Reset (rst_i=1 at clk edge): wptr=rptr=0, count_o=0, ovf_cnt_o=0, irq_o=0, latency_o=0, empty_o=1, full_o=0.
- Reset also sets the valid edge register prev_v=1 and prev_s=1, so a level already high at reset release does not capture.
- Push event: ct_valid_i=1 and prev_v=0; prev_v<=ct_valid_i every cycle.
- On a push with count<DEPTH: mem[wptr]<=ct_i, wptr<=wptr+1 (wraps at DEPTH), count+1. Data becomes visible on rdata_o the cycle after the edge.
- Push when full with no pop that cycle: block dropped, ovf_cnt_o+1, saturating at 255.
- Pop (pop_i=1): when count>0, rptr<=rptr+1 (wraps), count-1. When empty, ignored with no state change.
- Simultaneous push+pop, not empty: both performed, count unchanged, including when full (no overflow).
- Simultaneous push+pop when empty: push performed, pop ignored, count becomes 1.
- rdata_o: combinational mem[rptr] word per rd_sel_i; 32'h0 when empty.
- irq_o: registered, irq_o<=(next count>=THRESH). Updates the cycle after the causing event.
- clr_i: wptr=rptr=count=0, ovf_cnt_o=0, irq_o=0 next cycle. prev_v<=ct_valid_i as normal.
- Priority: rst_i > clr_i > push/pop. A push edge coincident with clr_i is discarded.
- Memory contents are not reset; only pointers and count are.
- Depth fixed at DEPTH; no other backpressure to the AES core (the core cannot stall).

Optional Feature:
- Macro: AES2_CT_LATENCY_EN.
- Defined:
  - Rising edge of start_i (start_i=1, prev_s=0) clears a 16-bit cycle counter and arms it.
  - While armed, the counter increments each cycle, saturating at 16'hFFFF.
  - On the next push event, latency_o is loaded with the counter value and the counter disarms.
  - A push edge with the counter unarmed leaves latency_o unchanged.
  - Reset and clr_i zero latency_o and disarm the counter.
- Undefined: latency_o tied to 16'h0; no counter logic.

Test Plan:
- Reset with ct_valid_i held 1, release, hold 3 cycles -> count_o=0, empty_o=1, no capture; then drop valid, raise with ct_i=128'h00112233_44556677_8899AABB_CCDDEEFF -> count_o=1; rd_sel_i=0..3 gives CCDDEEFF, 8899AABB, 44556677, 00112233.
- DEPTH=4: 6 valid pulses with distinct ct_i, no pops -> full_o=1, count_o=4, ovf_cnt_o=2; four pops return blocks 1-4 in order, then empty_o=1, rdata_o=0.
- Full FIFO, valid edge and pop_i in the same cycle -> count_o stays 4, ovf_cnt_o unchanged, head becomes block 2, tail holds the new block.
- THRESH=2: first push -> irq_o=0; second push -> irq_o=1 one cycle later; one pop -> irq_o=0 next cycle; pop on empty -> no change.
- clr_i coincident with a valid edge on a 3-entry FIFO with ovf_cnt_o=5 -> count_o=0, ovf_cnt_o=0, irq_o=0, nothing captured.
- With AES2_CT_LATENCY_EN: start_i rises, ct_valid_i rises 13 cycles later -> latency_o=13; without the macro -> latency_o=0.
